enc_quad_frontend: RTL

Per-channel front end for one quadrature encoder. It synchronizes and glitch-filters raw A/B lines, decodes 4x quadrature, and keeps a signed-wrap position count. It feeds the period-measurement stage directly with clean `a_filt`/`b_filt` levels and `dir`. It also gives the bus interface `pos`, a single-cycle `step` strobe and a sticky illegal-transition flag.

---
 rtl/enc_quad_frontend_if.sv | 26 ++
 rtl/enc_quad_frontend.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/enc_quad_frontend_if.sv
// rtl/enc_quad_frontend_if.sv - encoder front-end signal bundle
interface enc_quad_frontend_if #(
  parameter int POS_W = 24
);
  logic             a_in;
  logic             b_in;
  logic             set_pos;
  logic [POS_W-1:0] set_val;
  logic             err_clr;
  logic             a_filt;
  logic             b_filt;
  logic             dir;
  logic [POS_W-1:0] pos;
  logic             step;
  logic             err;

  modport master (
    output a_in, b_in, set_pos, set_val, err_clr,
    input  a_filt, b_filt, dir, pos, step, err
  );

  modport slave (
    input  a_in, b_in, set_pos, set_val, err_clr,
    output a_filt, b_filt, dir, pos, step, err
  );
endinterface

// File: rtl/enc_quad_frontend.sv
// rtl/enc_quad_frontend.sv - quadrature encoder sync, glitch filter, 4x decode and position count
// Optional glitch filter: define ENC_FILTER_EN.
module enc_quad_frontend #(
  parameter int FILT_LEN = 4,
  parameter int POS_W    = 24
) (
  input logic                clk,
  input logic                reset,
  enc_quad_frontend_if.slave bus
);

  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_filt_len_chk
    $error("FILT_LEN must be in 1..15");
  end

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q;
  logic             a_s1_q, a_s_q, b_s1_q, b_s_q;
  logic             a_filt_q, b_filt_q;
  logic             a_filt_d, b_filt_d;
  logic [1:0]       prev_q;
  logic [1:0]       fill_q;
  logic             dir_q, step_q, err_q;
  logic [POS_W-1:0] pos_q;
  logic             init_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1_q <= 1'b0;
      a_s_q  <= 1'b0;
      b_s1_q <= 1'b0;
      b_s_q  <= 1'b0;
    end else begin
      a_s1_q <= bus.a_in;
      a_s_q  <= a_s1_q;
      b_s1_q <= bus.b_in;
      b_s_q  <= b_s1_q;
    end
  end

`ifdef ENC_FILTER_EN
  localparam logic [3:0] FILT_M1 = 4'(FILT_LEN - 1);

  logic [3:0] fca_q, fcb_q, fca_d, fcb_d;
  logic [3:0] stab_q;
  logic [1:0] last_q;

  always_comb begin
    a_filt_d = a_filt_q;
    b_filt_d = b_filt_q;
    fca_d    = 4'd0;
    fcb_d    = 4'd0;
    if (a_s_q != a_filt_q) begin
      if (fca_q == FILT_M1) a_filt_d = a_s_q;
      else                  fca_d    = fca_q + 4'd1;
    end
    if (b_s_q != b_filt_q) begin
      if (fcb_q == FILT_M1) b_filt_d = b_s_q;
      else                  fcb_d    = fcb_q + 4'd1;
    end
  end

  assign init_done = fill_q[1] && ({a_s_q, b_s_q} == last_q) && (stab_q == FILT_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fca_q  <= 4'd0;
      fcb_q  <= 4'd0;
      stab_q <= 4'd0;
      last_q <= 2'b00;
    end else begin
      fca_q <= fca_d;
      fcb_q <= fcb_d;
      if (state_q == INIT) begin
        last_q <= {a_s_q, b_s_q};
        if (fill_q[1]) begin
          if ({a_s_q, b_s_q} != last_q) stab_q <= 4'd0;
          else if (stab_q != FILT_M1)   stab_q <= stab_q + 4'd1;
        end
      end
    end
  end
`else
  assign a_filt_d  = a_s_q;
  assign b_filt_d  = b_s_q;
  assign init_done = fill_q[1];
`endif

  // Map the Gray sequence 00,10,11,01 onto 0..3 so direction is the sign of the phase delta.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  logic [1:0] delta;
  logic       fwd, rev, bad;

  always_comb begin
    delta = phase({a_filt_q, b_filt_q}) - phase(prev_q);
    fwd   = (delta == 2'd1);
    rev   = (delta == 2'd3);
    bad   = (delta == 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= INIT;
      a_filt_q <= 1'b0;
      b_filt_q <= 1'b0;
      prev_q   <= 2'b00;
      fill_q   <= 2'd0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      a_filt_q <= a_filt_d;
      b_filt_q <= b_filt_d;
      step_q   <= 1'b0;
      if (bus.set_pos) pos_q <= bus.set_val;
      if (bus.err_clr) err_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          // Wait until the synchronizer holds live line values before seeding the decoder.
          if (!fill_q[1]) fill_q <= fill_q + 2'd1;
          if (init_done) begin
            a_filt_q <= a_s_q;
            b_filt_q <= b_s_q;
            prev_q   <= {a_s_q, b_s_q};
            state_q  <= RUN;
          end
        end
        RUN: begin
          prev_q <= {a_filt_q, b_filt_q};
          if (fwd) begin
            if (!bus.set_pos) pos_q <= pos_q + POS_W'(1);
            dir_q  <= 1'b1;
            step_q <= 1'b1;
          end else if (rev) begin
            if (!bus.set_pos) pos_q <= pos_q - POS_W'(1);
            dir_q  <= 1'b0;
            step_q <= 1'b1;
          end else if (bad) begin
            err_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.a_filt = a_filt_q;
  assign bus.b_filt = b_filt_q;
  assign bus.dir    = dir_q;
  assign bus.pos    = pos_q;
  assign bus.step   = step_q;
  assign bus.err    = err_q;

endmodule
